// File: rtl/oled_task_arbiter.sv
// rtl/oled_task_arbiter.sv - frame-aligned arbiter sharing one OLED pixel stream between task controllers
// Task changes only land on frame boundaries, with optional blank frames in between.
module oled_task_arbiter #(
    parameter int          N_TASKS      = 4,
    parameter int          BLANK_FRAMES = 1,
    parameter logic [15:0] BLANK_COLOUR = 16'h0000,
    localparam int         AW           = (N_TASKS > 1) ? $clog2(N_TASKS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_begin,
    input  logic [N_TASKS-1:0]      sw_req,
    input  logic [16*N_TASKS-1:0]   task_data,
    output logic [N_TASKS-1:0]      task_set,
    output logic [15:0]             oled_data,
    output logic [AW-1:0]           active_task,
    output logic                    switching
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        task_q, task_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [15:0]          oled_q, oled_d;
    logic [N_TASKS-1:0]   sync1_q, sync2_q;
    logic                 pend_vld_q, pend_vld_d;
    logic [AW-1:0]        pend_idx_q, pend_idx_d;
    logic                 fb_q;
    logic                 fb_rise;
    logic [15:0]          sel_pixel;

    assign fb_rise = frame_begin & ~fb_q;

    // Lowest asserted synchronized request wins.
    always_comb begin
        pend_vld_d = 1'b0;
        pend_idx_d = '0;
        for (int k = N_TASKS - 1; k >= 0; k--) begin
            if (sync2_q[k]) begin
                pend_vld_d = 1'b1;
                pend_idx_d = AW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        task_d  = task_q;
        cnt_d   = cnt_q;
        if (fb_rise) begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_vld_q) begin
                        if (BLANK_FRAMES == 0) begin
                            state_d = ST_ACTIVE;
                            task_d  = pend_idx_q;
                        end else begin
                            state_d = ST_BLANK;
                            cnt_d   = 4'(BLANK_FRAMES);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!pend_vld_q || (pend_idx_q != task_q)) begin
                        if (BLANK_FRAMES == 0) begin
                            if (pend_vld_q) begin
                                task_d = pend_idx_q;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            state_d = ST_BLANK;
                            cnt_d   = 4'(BLANK_FRAMES);
                        end
                    end
                end
                ST_BLANK: begin
                    cnt_d = cnt_q - 4'd1;
                    // Target is whatever is pending at exit; the countdown never restarts.
                    if (cnt_q <= 4'd1) begin
                        cnt_d = 4'd0;
                        if (pend_vld_q) begin
                            state_d = ST_ACTIVE;
                            task_d  = pend_idx_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_pixel = BLANK_COLOUR;
        for (int k = 0; k < N_TASKS; k++) begin
            if (task_d == AW'(k)) begin
                sel_pixel = task_data[16*k +: 16];
            end
        end
    end

    // Pixel follows the next state so the new task's first pixel lands right after frame_begin.
    assign oled_d = (state_d == ST_ACTIVE) ? sel_pixel : BLANK_COLOUR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            task_q     <= '0;
            cnt_q      <= 4'd0;
            oled_q     <= BLANK_COLOUR;
            sync1_q    <= '0;
            sync2_q    <= '0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            fb_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            task_q     <= task_d;
            cnt_q      <= cnt_d;
            oled_q     <= oled_d;
            sync1_q    <= sw_req;
            sync2_q    <= sync1_q;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            fb_q       <= frame_begin;
        end
    end

    always_comb begin
        task_set = '0;
        for (int k = 0; k < N_TASKS; k++) begin
            task_set[k] = (state_q == ST_ACTIVE) && (task_q == AW'(k));
        end
    end

    assign oled_data   = oled_q;
    assign active_task = task_q;
    assign switching   = (state_q == ST_BLANK);

endmodule

// File: doc/oled_task_arbiter.md
Name: oled_task_arbiter

Overview:
- Shares the single OLED pixel stream between N_TASKS task controllers (task P, Q, R, S, ...), selected by slide-switch requests.
- Task changes take effect only on frame boundaries, with BLANK_FRAMES blank frames inserted between tasks.
- The block drives each task's `set` enable, so a deselected task is held in its reset/idle state.
- Sits between the task controllers and the OLED driver in the top level.

Parameters:
- N_TASKS, 4: number of task sources / request switches (2..8).
- BLANK_FRAMES, 1: full frames output as BLANK_COLOUR on each task change (0..15; 0 = switch directly).
- BLANK_COLOUR, 16'h0000: RGB565 colour shown while blanking or when no task is selected.

Ports:
- clk  in  1  100 MHz system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_begin  in  1  one-cycle pulse from the OLED driver at pixel_index 0 of each frame.
- sw_req  in  N_TASKS  raw (asynchronous) task request switches; bit k requests task k.
- task_data  in  16*N_TASKS  pixel colour from each task; task k occupies bits [16k+15:16k].
- task_set  out  N_TASKS  one-hot enable to task controllers; all-zero when idle or blanking.
- oled_data  out  16  registered pixel colour to the OLED driver.
- active_task  out  clog2(N_TASKS)  index of the task currently displayed; holds its last value when not ACTIVE.
- switching  out  1  high while in BLANK.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; oled_data = BLANK_COLOUR; task_set = 0; active_task = 0; switching = 0.
  - Synchronizer flops = 0; pending target = none; frame counter = 0.
- Input conditioning:
  - sw_req passes through a 2-flop synchronizer, so the requested target is visible 2 cycles after a switch edge.
  - Target = lowest-index asserted synchronized bit; no bit asserted = "none".
  - The target is re-evaluated every cycle into the pending register.
- States: IDLE (no task), BLANK (frame countdown), ACTIVE (task k).
- IDLE:
  - oled_data <= BLANK_COLOUR; task_set = 0.
  - On frame_begin with pending != none: enter BLANK with counter = BLANK_FRAMES; if BLANK_FRAMES = 0, go straight to ACTIVE(pending).
- ACTIVE(k):
  - oled_data <= task_data[k] (1-cycle latency); task_set = one-hot(k); active_task = k.
  - On frame_begin with pending != k (including none): enter BLANK with counter = BLANK_FRAMES; task_set drops to 0 in the same cycle, which resets task k.
  - If BLANK_FRAMES = 0: go directly to ACTIVE(pending) or IDLE; task_set changes in that single cycle.
- BLANK:
  - oled_data <= BLANK_COLOUR; switching = 1; task_set = 0.
  - Each frame_begin decrements the counter.
  - On the frame_begin that decrements the counter to 0: go to ACTIVE(pending) if pending != none, else IDLE. The new task's first pixel is on the cycle after that frame_begin.
  - Pending may change during BLANK: the counter is not restarted, and the target taken is the pending value at exit. Returning to the previous task still completes the full blank.
- Switch edges between frame_begin pulses are never applied mid-frame. A request that toggles and reverts before the next frame_begin causes no transition.
- frame_begin and a pending change arriving in the same cycle: frame_begin samples the pending value registered before that cycle. The change applies at the following frame_begin.
- Reset asserted mid-BLANK or mid-ACTIVE: immediately IDLE / BLANK_COLOUR. After release, a transition occurs only at the next frame_begin.
- frame_begin wider than one cycle: only the rising edge counts (edge-detected internally).

Test Plan:
- Reset, then sw_req = 4'b0100 and one frame_begin (BLANK_FRAMES = 1):
  - switching = 1, oled_data = 16'h0000.
  - Next frame_begin: task_set = 4'b0100, active_task = 2.
  - oled_data = task_data[2] one cycle later.
- Priority: sw_req = 4'b1010 -> task 1 selected after the blank. Then clear bit 1 -> after the next frame_begin plus one blank frame, task 3 is active.
- Mid-frame toggle: in ACTIVE(0), raise sw_req[0] = 0 then back to 1 within one frame -> no BLANK; task_set stays 4'b0001 throughout.
- Retarget during BLANK (BLANK_FRAMES = 3):
  - Request changes 0 -> 1, then -> 2 in the second blank frame.
  - Exactly 3 blank frames occur, then task_set = 4'b0100.
- All switches off in ACTIVE(3) -> at frame_begin, BLANK for 1 frame, then IDLE; task_set = 0, oled_data = BLANK_COLOUR.
- Async reset asserted in ACTIVE(1) mid-frame -> oled_data = 0 and task_set = 0 without waiting for a clock edge. After release, task 1 is not re-enabled until frame_begin plus the blank.
